cosine_job_ctrl: RTL

//  Initiator/front-end for the cosine similarity core. Accepts W element pairs
//  (a[i], b[i]) over a valid/ready stream and packs them into parallel vector

---
 rtl/cosine_job_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cosine_job_ctrl.sv
// rtl/cosine_job_ctrl.sv - element-pair loader, core start/result capture and response port for the cosine core
// Optional watchdog on the core result: define CSJ_WATCHDOG_EN.
module cosine_job_ctrl #(
  parameter int W       = 5,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_last,
  output logic            core_start,
  output logic [32*W-1:0] core_vec_a,
  output logic [32*W-1:0] core_vec_b,
  input  logic [31:0]     core_sim,
  input  logic            core_valid,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic            res_err,
  output logic            busy
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(W - 1);
  localparam logic [31:0]     QNAN     = 32'h7FC00000;

  if ((2 ** IDXW) < W) begin : g_bad_idxw
    $error("IDXW too narrow for W");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  err_q, err_d;
  logic [W-1:0][31:0]    vec_a_q, vec_a_d;
  logic [W-1:0][31:0]    vec_b_q, vec_b_d;
  logic [31:0]           res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;

`ifdef CSJ_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    vec_a_d    = vec_a_q;
    vec_b_d    = vec_b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
`ifdef CSJ_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          vec_a_d[idx_q] = in_a;
          vec_b_d[idx_q] = in_b;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_ISSUE;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            // Short job: pad the tail so the core sees a full-width vector.
            for (int j = 0; j < W; j++) begin
              if (j > int'(idx_q)) begin
                vec_a_d[j] = 32'h0;
                vec_b_d[j] = 32'h0;
              end
            end
            err_d   = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef CSJ_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (core_valid) begin
          res_data_d = core_sim;
          res_err_d  = err_q;
          state_d    = ST_RESP;
        end
`ifdef CSJ_WATCHDOG_EN
        else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          res_data_d = QNAN;
          res_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        if (res_ready) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
          vec_a_d = '0;
          vec_b_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      err_q      <= 1'b0;
      vec_a_q    <= '0;
      vec_b_q    <= '0;
      res_data_q <= 32'h0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      vec_a_q    <= vec_a_d;
      vec_b_q    <= vec_b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

`ifdef CSJ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end
`endif

  // All handshake outputs decode registered state, so no input-to-output paths.
  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_LOAD);
  assign core_start = (state_q == ST_ISSUE);
  assign res_valid  = (state_q == ST_RESP);
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign core_vec_a = vec_a_q;
  assign core_vec_b = vec_b_q;

endmodule
